// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit feeder: header sizes, read-side
// FSM states, output word source select and length helpers.
package udp_pkg;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [15:0] IP_HDR_BYTES  = 16'd20;
    localparam logic [15:0] WORD_BYTES    = 16'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_SEQ  = 2'd2
    } out_sel_e;

    // UDP length field: header plus payload bytes.
    function automatic logic [15:0] udp_length(input logic [15:0] words);
        return UDP_HDR_BYTES + WORD_BYTES * words;
    endfunction

    // IP total length field: IP header plus the whole UDP datagram.
    function automatic logic [15:0] ip_total_length(input logic [15:0] words);
        return udp_length(words) + IP_HDR_BYTES;
    endfunction

endpackage

// File: rtl/tx_pingpong_ram.sv
// Two-bank payload store. The address MSB selects the bank; writes are
// synchronous and reads come out of a register one cycle after re.
module tx_pingpong_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2*DEPTH];

    // Write port: store one accepted word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Packs the 32-bit sample stream into ping-pong banks and hands each closed
// bank to the UDP transmit stage with its UDP/IP length fields.
// Optional build macro PKT_SEQ_EN: word 0 of every packet is a 32-bit
// sequence number, leaving PAYLOAD_WORDS_MAX-1 sample slots per bank.
//
// Handshakes: an input word transfers on a rising edge where s_valid and
// s_ready are both high; s_ready never depends on s_valid. tx_start pulses
// for one cycle with the lengths already valid; each cycle tx_data_req is
// high returns one payload word on tx_data on the following cycle.
module udp_tx_packetizer
    import udp_pkg::*;
#(
    parameter int PAYLOAD_WORDS_MAX = 256,
    parameter int GAP_CYCLES        = 96
) (
    input  logic        e_rxc,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        tx_start,
    input  logic        tx_data_req,
    output logic [31:0] tx_data,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        overrun_err
);

    localparam int AW = $clog2(PAYLOAD_WORDS_MAX);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_SLOT = AW'(PAYLOAD_WORDS_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
`ifdef PKT_SEQ_EN
    localparam logic [AW-1:0] FIRST_SLOT = AW'(1);
`else
    localparam logic [AW-1:0] FIRST_SLOT = '0;
`endif

    // Write side and bank bookkeeping
    logic               active;
    logic               wr_bank, wr_bank_nxt;
    logic [AW-1:0]      wr_ptr;
    logic [1:0]         pending, pending_nxt;
    logic [1:0][CW-1:0] count;
    logic               accept, close_bank, release_bank;

    // Read side
    rd_state_e          state, state_nxt;
    logic               rd_bank;
    logic [CW-1:0]      rd_ptr, rd_cnt;
    logic [GW-1:0]      gap_cnt;
    logic               req_ok, req_bad, ram_re, first_word;
    out_sel_e           out_sel;
    logic [31:0]        ram_q;

    // Counts include the sequence slot when present, so lengths need no offset.
    assign s_ready      = active & ~pending[wr_bank];
    assign accept       = s_valid & s_ready;
    assign close_bank   = accept & (s_last | (wr_ptr == LAST_SLOT));
    assign rd_cnt       = count[rd_bank];
    assign req_ok       = tx_data_req & (state == SEND) & (rd_ptr < rd_cnt);
    assign req_bad      = tx_data_req & ~req_ok;
    assign release_bank = (state == GAP) & (gap_cnt == GAP_LAST);

    // Next bank flags: release first, then close, so a freed bank is reused at once.
    always_comb begin
        pending_nxt = pending;
        if (release_bank) pending_nxt[rd_bank] = 1'b0;
        if (close_bank)   pending_nxt[wr_bank] = 1'b1;
        wr_bank_nxt = wr_bank;
        if (pending_nxt[wr_bank] && !pending_nxt[~wr_bank]) wr_bank_nxt = ~wr_bank;
    end

    // Write control: pointer, bank flip, word counts and pending flags.
    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            wr_bank <= 1'b0;
            wr_ptr  <= FIRST_SLOT;
            pending <= '0;
            count   <= '0;
        end else begin
            active  <= 1'b1;
            pending <= pending_nxt;
            wr_bank <= wr_bank_nxt;
            if (close_bank) begin
                count[wr_bank] <= CW'(wr_ptr) + CW'(1);
                wr_ptr         <= FIRST_SLOT;
            end else if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending[rd_bank]) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (req_ok && (rd_ptr + CW'(1) == rd_cnt)) state_nxt = GAP;
            GAP:     if (release_bank) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM registers, length fields, word source select and overrun flag.
    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rd_bank         <= 1'b0;
            rd_ptr          <= '0;
            gap_cnt         <= '0;
            tx_start        <= 1'b0;
            tx_data_length  <= '0;
            tx_total_length <= '0;
            out_sel         <= SEL_ZERO;
            overrun_err     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_start <= (state == LOAD);
            gap_cnt  <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (release_bank) rd_bank <= ~rd_bank;
            if (state == LOAD) begin
                rd_ptr          <= '0;
                tx_data_length  <= udp_length(16'(rd_cnt));
                tx_total_length <= ip_total_length(16'(rd_cnt));
            end else if (req_ok) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (req_ok) begin
                out_sel <= first_word ? SEL_SEQ : SEL_RAM;
            end else if (req_bad) begin
                out_sel     <= SEL_ZERO;
                overrun_err <= 1'b1;
            end
        end
    end

`ifdef PKT_SEQ_EN
    logic [31:0] seq_cnt, seq_word;

    // Sequence number: captured for the packet being loaded, then advanced.
    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            seq_cnt  <= '0;
            seq_word <= '0;
        end else if (state == LOAD) begin
            seq_word <= seq_cnt;
            seq_cnt  <= seq_cnt + 32'd1;
        end
    end

    assign first_word = (rd_ptr == '0);
`else
    assign first_word = 1'b0;
`endif

    assign ram_re = req_ok & ~first_word;

    // Output word: RAM read register, sequence word, or zero after overrun/reset.
    always_comb begin
        tx_data = '0;
        case (out_sel)
            SEL_RAM: tx_data = ram_q;
`ifdef PKT_SEQ_EN
            SEL_SEQ: tx_data = seq_word;
`endif
            default: tx_data = '0;
        endcase
    end

    tx_pingpong_ram #(
        .DEPTH (PAYLOAD_WORDS_MAX)
    ) u_ram (
        .clk   (e_rxc),
        .rst_n (reset_n),
        .we    (accept),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (s_data),
        .re    (ram_re),
        .raddr ({rd_bank, rd_ptr[AW-1:0]}),
        .rdata (ram_q)
    );

endmodule
